fetch_pc_gen: RTL

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen_pkg.sv | 26 ++
 rtl/fetch_pc_gen_if.sv | 51 +++++
 rtl/fetch_ras.sv | 43 ++++
 rtl/fetch_pc_gen.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and helpers for the fetch PC generator and its return stack.
package fetch_pc_gen_pkg;

  typedef enum logic [1:0] {
    BR_RET  = 2'b00,
    BR_CALL = 2'b01,
    BR_JUMP = 2'b10,
    BR_COND = 2'b11
  } br_type_e;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_MISS_WAIT = 1'b1
  } fetch_state_e;

  localparam int DEF_FETCH_WIDTH = 4;
  localparam int DEF_PC_W        = 32;
  localparam int DEF_INST_BYTES  = 8;
  localparam int DEF_RAS_DEPTH   = 16;

  // Index width that never collapses to zero bits (FETCH_WIDTH=1 still needs a slot field).
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Redirect, BTB and bundle-output bundle between the fetch PC generator and its neighbours.
interface fetch_pc_gen_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int PC_W        = 32,
  parameter int RAS_DEPTH   = 16
);
  localparam int RAS_W = $clog2(RAS_DEPTH);
  localparam int TS_W  = $clog2(FETCH_WIDTH) + 1;

  logic                     stall_i;
  logic                     recoverFlag_i;
  logic [PC_W-1:0]          recoverPC_i;
  logic                     exceptionFlag_i;
  logic [PC_W-1:0]          exceptionPC_i;
  logic                     flagRecoverEX_i;
  logic [PC_W-1:0]          targetAddrEX_i;
  logic                     flagRecoverID_i;
  logic [PC_W-1:0]          targetAddrID_i;
  logic                     flagRtrID_i;
  logic                     flagCallID_i;
  logic [PC_W-1:0]          callPCID_i;
  logic [RAS_W-1:0]         rasTosID_i;
  logic [FETCH_WIDTH-1:0]   btbHit_i;
  logic [2*FETCH_WIDTH-1:0] btbType_i;
  logic [PC_W*FETCH_WIDTH-1:0] btbTarget_i;
  logic [FETCH_WIDTH-1:0]   prediction_i;
  logic                     icacheMiss_i;
  logic                     fillDone_i;
  logic [PC_W-1:0]          pc_o;
  logic                     valid_o;
  logic [FETCH_WIDTH-1:0]   slotMask_o;
  logic [TS_W-1:0]          takenSlot_o;
  logic [RAS_W-1:0]         rasTos_o;

  modport slave (
    input  stall_i, recoverFlag_i, recoverPC_i, exceptionFlag_i, exceptionPC_i,
           flagRecoverEX_i, targetAddrEX_i, flagRecoverID_i, targetAddrID_i,
           flagRtrID_i, flagCallID_i, callPCID_i, rasTosID_i,
           btbHit_i, btbType_i, btbTarget_i, prediction_i, icacheMiss_i, fillDone_i,
    output pc_o, valid_o, slotMask_o, takenSlot_o, rasTos_o
  );

  modport master (
    output stall_i, recoverFlag_i, recoverPC_i, exceptionFlag_i, exceptionPC_i,
           flagRecoverEX_i, targetAddrEX_i, flagRecoverID_i, targetAddrID_i,
           flagRtrID_i, flagCallID_i, callPCID_i, rasTosID_i,
           btbHit_i, btbType_i, btbTarget_i, prediction_i, icacheMiss_i, fillDone_i,
    input  pc_o, valid_o, slotMask_o, takenSlot_o, rasTos_o
  );

endinterface

// File: rtl/fetch_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry, underflow wraps.
module fetch_ras #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 16,
  parameter int RAS_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             restore_i,
  input  logic [RAS_W-1:0] restore_tos_i,
  input  logic [PC_W-1:0]  push_data_i,
  input  logic [RAS_W-1:0] rd_idx_i,
  output logic [PC_W-1:0]  rd_data_o,
  output logic [PC_W-1:0]  top_o,
  output logic [RAS_W-1:0] tos_o
);

  logic [PC_W-1:0]  r_stack [RAS_DEPTH];
  logic [RAS_W-1:0] r_tos;
  logic [RAS_W-1:0] w_base_tos;
  logic [RAS_W-1:0] w_new_tos;

  // A restore rebases the pointer first, so ID call/return adjust the checkpoint, not the live TOS.
  assign w_base_tos = restore_i ? restore_tos_i : r_tos;
  assign w_new_tos  = w_base_tos + RAS_W'(push_i) - RAS_W'(pop_i);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tos <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_stack[i] <= '0;
    end else begin
      r_tos <= w_new_tos;
      if (push_i) r_stack[w_new_tos] <= push_data_i;
    end
  end

  assign top_o     = r_stack[r_tos];
  assign rd_data_o = r_stack[rd_idx_i];
  assign tos_o     = r_tos;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: redirect priority, BTB slot selection and I-cache miss wait.
// Optional return stack enabled by defining FETCH_RAS_EN.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int PC_W        = DEF_PC_W,
  parameter int INST_BYTES  = DEF_INST_BYTES,
  parameter int RAS_DEPTH   = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  fetch_pc_gen_if.slave   bus
);

  localparam int IB_W   = $clog2(INST_BYTES);
  localparam int SLOT_W = clog2_min1(FETCH_WIDTH);
  localparam int TS_W   = $clog2(FETCH_WIDTH) + 1;
  localparam int RAS_W  = $clog2(RAS_DEPTH);
  localparam logic [PC_W-1:0] BLOCK_BYTES = PC_W'(FETCH_WIDTH * INST_BYTES);
  localparam logic [PC_W-1:0] BASE_MASK   = ~(BLOCK_BYTES - PC_W'(1));

  logic [PC_W-1:0]        r_pc;
  fetch_state_e           r_state;
  logic [SLOT_W-1:0]      w_first;
  logic [SLOT_W-1:0]      w_t;
  logic [FETCH_WIDTH-1:0] w_eff;
  logic [FETCH_WIDTH-1:0] w_mask;
  logic                   w_any_taken;
  logic                   w_valid;
  logic                   w_fire;
  logic                   w_id_redir;
  logic                   w_redir;
  logic [PC_W-1:0]        w_base;
  logic [PC_W-1:0]        w_seq;
  logic [PC_W-1:0]        w_t_target;
  logic [PC_W-1:0]        w_taken_pc;
  logic [PC_W-1:0]        w_id_pc;

  assign w_base     = r_pc & BASE_MASK;
  assign w_seq      = w_base + BLOCK_BYTES;
  assign w_first    = SLOT_W'((r_pc >> IB_W) & PC_W'(FETCH_WIDTH - 1));
  assign w_valid    = (r_state == ST_RUN) & ~bus.icacheMiss_i;
  assign w_fire     = w_valid & ~bus.stall_i;
  assign w_id_redir = bus.flagRecoverID_i & ~bus.stall_i;
  assign w_redir    = bus.recoverFlag_i | bus.exceptionFlag_i | bus.flagRecoverEX_i | w_id_redir;
  assign w_t_target = bus.btbTarget_i[int'(w_t)*PC_W +: PC_W];

  for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
    assign w_eff[gi]  = bus.btbHit_i[gi]
                      & ((bus.btbType_i[2*gi +: 2] != BR_COND) | bus.prediction_i[gi])
                      & (SLOT_W'(gi) >= w_first);
    assign w_mask[gi] = w_valid & (SLOT_W'(gi) >= w_first) & (SLOT_W'(gi) <= w_t);
  end

  // Lowest effective-taken slot wins; with none taken the bundle runs to the last slot.
  always_comb begin
    w_any_taken = 1'b0;
    w_t         = SLOT_W'(FETCH_WIDTH - 1);
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (w_eff[i]) begin
        w_any_taken = 1'b1;
        w_t         = SLOT_W'(i);
      end
    end
  end

`ifdef FETCH_RAS_EN
  logic [1:0]       w_t_type;
  logic             w_fetch_push;
  logic             w_fetch_pop;
  logic [PC_W-1:0]  w_call_ret;
  logic [PC_W-1:0]  w_ras_top;
  logic [PC_W-1:0]  w_ras_ckpt;
  logic [RAS_W-1:0] w_ras_tos;

  assign w_t_type     = bus.btbType_i[2*int'(w_t) +: 2];
  assign w_fetch_push = w_fire & w_any_taken & ~w_redir & (w_t_type == BR_CALL);
  assign w_fetch_pop  = w_fire & w_any_taken & ~w_redir & (w_t_type == BR_RET);
  assign w_call_ret   = w_base + PC_W'((int'(w_t) + 1) * INST_BYTES);
  assign w_taken_pc   = (w_t_type == BR_RET) ? w_ras_top : w_t_target;
  assign w_id_pc      = bus.flagRtrID_i ? w_ras_ckpt : bus.targetAddrID_i;
  assign bus.rasTos_o = w_ras_tos;

  fetch_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_W     (RAS_W)
  ) u_ras (
    .clk           (clk),
    .reset         (reset),
    .push_i        (w_id_redir ? bus.flagCallID_i : w_fetch_push),
    .pop_i         (w_id_redir ? bus.flagRtrID_i  : w_fetch_pop),
    .restore_i     (w_id_redir),
    .restore_tos_i (bus.rasTosID_i),
    .push_data_i   (w_id_redir ? bus.callPCID_i : w_call_ret),
    .rd_idx_i      (bus.rasTosID_i),
    .rd_data_o     (w_ras_ckpt),
    .top_o         (w_ras_top),
    .tos_o         (w_ras_tos)
  );
`else
  logic w_unused_ras;
  assign w_unused_ras = ^{bus.flagRtrID_i, bus.flagCallID_i, bus.callPCID_i, bus.rasTosID_i};
  assign w_taken_pc   = w_t_target;
  assign w_id_pc      = bus.targetAddrID_i;
  assign bus.rasTos_o = '0;
`endif

  // Commit/exception/EX redirects bypass stall and abandon a pending miss.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= '0;
      r_state <= ST_RUN;
    end else if (bus.recoverFlag_i) begin
      r_pc    <= bus.recoverPC_i;
      r_state <= ST_RUN;
    end else if (bus.exceptionFlag_i) begin
      r_pc    <= bus.exceptionPC_i;
      r_state <= ST_RUN;
    end else if (bus.flagRecoverEX_i) begin
      r_pc    <= bus.targetAddrEX_i;
      r_state <= ST_RUN;
    end else if (w_id_redir) begin
      r_pc    <= w_id_pc;
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!bus.stall_i) begin
            if (bus.icacheMiss_i) r_state <= ST_MISS_WAIT;
            else                  r_pc    <= w_any_taken ? w_taken_pc : w_seq;
          end
        end
        ST_MISS_WAIT: begin
          if (bus.fillDone_i) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc_o        = r_pc;
  assign bus.valid_o     = w_valid;
  assign bus.slotMask_o  = w_mask;
  assign bus.takenSlot_o = (w_valid & w_any_taken) ? TS_W'(w_t) : TS_W'(FETCH_WIDTH);

endmodule
